// File: rtl/fir_filter_param_pkg.sv
// Shared helpers for the parametrised FIR filter: accumulator sizing and
// output saturation bounds. Used by the filter RTL and its benches.
package fir_filter_param_pkg;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int unsigned fir_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Accumulator width that holds the sum of ntaps full-width products
  // without overflow.
  function automatic int unsigned fir_aw(input int unsigned dw,
                                         input int unsigned cw,
                                         input int unsigned ntaps);
    return dw + cw + fir_clog2(ntaps);
  endfunction

  // Largest value representable as a signed dw-bit sample.
  function automatic longint fir_sat_hi(input int unsigned dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable as a signed dw-bit sample.
  function automatic longint fir_sat_lo(input int unsigned dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Streaming sample/coefficient interface between a source, the FIR filter
// and a sink. The source side (master) drives samples, control and
// coefficients; the filter side (slave) returns the filtered stream.
interface fir_filter_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
);
  logic signed [DW-1:0] DIN;
  logic                 VIN;
  logic                 CLR;
  logic                 COEF_LD;
  logic signed [CW-1:0] COEF_IN;
  logic signed [DW-1:0] DOUT;
  logic                 VOUT;

  modport master (
    output DIN, VIN, CLR, COEF_LD, COEF_IN,
    input  DOUT, VOUT
  );

  modport slave (
    input  DIN, VIN, CLR, COEF_LD, COEF_IN,
    output DOUT, VOUT
  );
endinterface

// File: rtl/fir_filter_param_tap.sv
// One FIR tap: a delay-line register, a coefficient register and a
// registered product of the tap input sample and its coefficient.
// Taps chain x_o -> x_i (towards older samples) and coef_o -> coef_i
// (coefficients move from the last tap towards tap 0 during a load).
module fir_tap #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    shift_i,
  input  logic                    load_i,
  input  logic                    clr_i,
  input  logic signed [DW-1:0]    x_i,
  output logic signed [DW-1:0]    x_o,
  input  logic signed [CW-1:0]    coef_i,
  output logic signed [CW-1:0]    coef_o,
  output logic signed [DW+CW-1:0] prod_o
);
  localparam int unsigned PW = DW + CW;

  logic signed [DW-1:0] x_q;
  logic signed [CW-1:0] coef_q;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] prod_d;

  // Full-precision signed product of the sample entering this tap.
  always_comb begin
    prod_d = PW'(x_i) * PW'(coef_q);
  end

  // Delay line and product advance on accepted samples; clear flushes both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      prod_q <= '0;
    end else if (clr_i) begin
      x_q    <= '0;
      prod_q <= '0;
    end else if (shift_i) begin
      x_q    <= x_i;
      prod_q <= prod_d;
    end
  end

  // Coefficient shift register; independent of clear so both can act together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coef_q <= '0;
    end else if (load_i) begin
      coef_q <= coef_i;
    end
  end

  assign x_o    = x_q;
  assign coef_o = coef_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR filter with a serial coefficient load port.
// Stage 1 (inside the taps) registers the NTAPS products; stage 2 sums,
// scales and optionally saturates them into DOUT. VOUT follows accepted
// samples with a two-register valid pipeline that a clear flushes.
module fir_filter_param
  import fir_filter_param_pkg::*;
#(
  parameter int unsigned NTAPS     = 11,
  parameter int unsigned DW        = 8,
  parameter int unsigned CW        = 8,
  parameter int unsigned OUT_SHIFT = 7,
  parameter bit          SAT       = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_n,
  fir_filter_param_if.slave fir
);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned AW = fir_aw(DW, CW, NTAPS);
  localparam logic signed [AW-1:0] SAT_HI = AW'(fir_sat_hi(DW));
  localparam logic signed [AW-1:0] SAT_LO = AW'(fir_sat_lo(DW));

  logic accept;

  // Chain element k feeds tap k; element NTAPS of each chain is the far end.
  logic signed [DW-1:0] x_chain [NTAPS+1];
  logic signed [CW-1:0] h_chain [NTAPS+1];
  logic signed [PW-1:0] prod    [NTAPS];

  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] scaled;
  logic signed [DW-1:0] dout_d;
  logic signed [DW-1:0] dout_q;
  logic                 v1_q;
  logic                 v1_d;
  logic                 vout_q;
  logic                 vout_d;

  // A sample enters only when no load or clear is competing for the cycle.
  assign accept = fir.VIN & ~fir.COEF_LD & ~fir.CLR;

  assign x_chain[0]     = fir.DIN;
  assign h_chain[NTAPS] = fir.COEF_IN;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .DW (DW),
      .CW (CW)
    ) u_tap (
      .clk_i  (CLK),
      .rst_ni (RST_n),
      .shift_i(accept),
      .load_i (fir.COEF_LD),
      .clr_i  (fir.CLR),
      .x_i    (x_chain[k]),
      .x_o    (x_chain[k+1]),
      .coef_i (h_chain[k+1]),
      .coef_o (h_chain[k]),
      .prod_o (prod[k])
    );
  end

  // Sum of the registered products, sign-extended to the full accumulator.
  always_comb begin
    acc_d = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      acc_d = acc_d + AW'(prod[k]);
    end
  end

  // Output scaling: arithmetic shift floors toward -inf; saturate or wrap.
  always_comb begin
    scaled = acc_d >>> OUT_SHIFT;
    dout_d = acc_d[OUT_SHIFT +: DW];
    if (SAT) begin
      if (scaled > SAT_HI) begin
        dout_d = SAT_HI[DW-1:0];
      end else if (scaled < SAT_LO) begin
        dout_d = SAT_LO[DW-1:0];
      end
    end
  end

  // Valid pipeline next state; a clear kills both in-flight stages.
  always_comb begin
    v1_d   = accept;
    vout_d = v1_q & ~fir.CLR;
  end

  // Valid pipeline and output register; DOUT holds between valid outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      v1_q   <= 1'b0;
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      v1_q   <= v1_d;
      vout_q <= vout_d;
      if (vout_d) begin
        dout_q <= dout_d;
      end
    end
  end

  assign fir.DOUT = dout_q;
  assign fir.VOUT = vout_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: six instances covering two geometries
// (11,8,8) and (4,12,10), each with OUT_SHIFT/SAT modes (0,wrap),
// (7,sat) and (7,wrap). All share one stimulus stream; each has its own
// reference model built from the filter equation on sample/coef queues.
module tb_fir_filter_param;

  logic        CLK;
  logic        RST_n;
  logic        vin;
  logic        clr;
  logic        ld;
  logic [31:0] din_raw;
  logic [31:0] coef_raw;

  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int unsigned NT   = (g < 3) ? 11 : 4;
    localparam int unsigned DW   = (g < 3) ? 8 : 12;
    localparam int unsigned CW   = (g < 3) ? 8 : 10;
    localparam int unsigned OS   = (g % 3 == 0) ? 0 : 7;
    localparam bit          SATM = (g % 3 == 1);

    fir_filter_param_if #(.DW(DW), .CW(CW)) f ();

    assign f.DIN     = din_raw[DW-1:0];
    assign f.VIN     = vin;
    assign f.CLR     = clr;
    assign f.COEF_LD = ld;
    assign f.COEF_IN = coef_raw[CW-1:0];

    fir_filter_param #(
      .NTAPS    (NT),
      .DW       (DW),
      .CW       (CW),
      .OUT_SHIFT(OS),
      .SAT      (SATM)
    ) u_dut (
      .CLK  (CLK),
      .RST_n(RST_n),
      .fir  (f)
    );

    // Reference state: h[k] = H[k], x[k] = x[n-k], pending outputs with due edge.
    longint h[$];
    longint x[$];
    longint due_q[$];
    longint val_q[$];
    longint edge_n;
    logic   exp_vout;
    longint exp_dout;

    function automatic longint scale(input longint y);
      longint s;
      longint w;
      s = y >>> OS;
      w = s & ((64'sd1 <<< DW) - 64'sd1);
      if (w >= (64'sd1 <<< (DW - 1))) w = w - (64'sd1 <<< DW);
      if (SATM) begin
        if (s > (64'sd1 <<< (DW - 1)) - 64'sd1) w = (64'sd1 <<< (DW - 1)) - 64'sd1;
        else if (s < -(64'sd1 <<< (DW - 1))) w = -(64'sd1 <<< (DW - 1));
      end
      return w;
    endfunction

    initial begin
      for (int i = 0; i < NT; i++) begin
        h.push_back(0);
        x.push_back(0);
      end
      edge_n   = 0;
      exp_vout = 1'b0;
      exp_dout = 0;
    end

    always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        for (int i = 0; i < NT; i++) begin
          h[i] = 0;
          x[i] = 0;
        end
        due_q.delete();
        val_q.delete();
        exp_vout = 1'b0;
        exp_dout = 0;
      end else begin
        longint y;
        edge_n++;
        if (clr) begin
          for (int i = 0; i < NT; i++) x[i] = 0;
          while (due_q.size() > 0 && due_q[$] >= edge_n) begin
            void'(due_q.pop_back());
            void'(val_q.pop_back());
          end
        end
        exp_vout = 1'b0;
        if (due_q.size() > 0 && due_q[0] == edge_n) begin
          exp_vout = 1'b1;
          exp_dout = val_q.pop_front();
          void'(due_q.pop_front());
        end
        if (vin && !ld && !clr) begin
          x.push_front(longint'(f.DIN));
          void'(x.pop_back());
          y = 0;
          for (int k = 0; k < NT; k++) y += h[k] * x[k];
          due_q.push_back(edge_n + 1);
          val_q.push_back(scale(y));
        end
        if (ld) begin
          h.push_back(longint'(f.COEF_IN));
          void'(h.pop_front());
        end
      end
    end

    always @(negedge CLK) begin
      check_val($sformatf("g%0d vout", g), longint'(f.VOUT), longint'(exp_vout));
      check_val($sformatf("g%0d dout", g), longint'(f.DOUT), exp_dout);
    end

    always @(negedge RST_n) begin
      #1;
      check_val($sformatf("g%0d rst_vout", g), longint'(f.VOUT), 0);
      check_val($sformatf("g%0d rst_dout", g), longint'(f.DOUT), 0);
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic c,
                      input logic l, input logic [31:0] hc);
    vin      = v;
    din_raw  = d;
    clr      = c;
    ld       = l;
    coef_raw = hc;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vin      = 1'b0;
    clr      = 1'b0;
    ld       = 1'b0;
    din_raw  = '0;
    coef_raw = '0;
    RST_n    = 1'b1;
    #3 RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;

    // Impulse: H = 1..11 (4-tap keeps the last four words, 8..11).
    for (int k = 1; k <= 11; k++) step(1'b0, 32'd0, 1'b0, 1'b1, 32'(k));
    step(1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 14; i++) step(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    idle(3);

    // Step response with all coefficients 127 and DIN = 127.
    for (int k = 0; k < 11; k++) step(1'b0, 32'd0, 1'b0, 1'b1, 32'd127);
    for (int i = 0; i < 20; i++) step(1'b1, 32'd127, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    idle(2);

    // Bubbles: VIN pattern 1,0,0,1,1,0,1 with random samples.
    for (int r = 0; r < 4; r++) begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++) step(pat[i], $urandom, 1'b0, 1'b0, 32'd0);
    end
    idle(2);

    // Reload in flight: samples offered during the load are dropped.
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 11; k++) step(1'b1, $urandom, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);

    // Clear mid-stream, then clear together with a coefficient shift.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    step(1'b1, $urandom, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    step(1'b1, $urandom, 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);

    // Random traffic with occasional clears and coefficient shifts.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 70), $urandom,
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 6), $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);

    // Asynchronous reset mid-cycle, then an impulse through zeroed coefficients.
    @(posedge CLK);
    #2 RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    step(1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);

    // Reload and run a short random stream after reset.
    for (int k = 0; k < 11; k++) step(1'b0, 32'd0, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 32'd0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
